// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - streams LEN words from BASE_ADDR out of a two_port_mem read port
// Optional stall counter port enabled by MEM_STREAM_READER_STALL_CNT_EN.
module mem_stream_reader #(
  parameter  int BIT_LENGTH = 64,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         addrb,
  output logic                  enb,
  input  logic [BIT_LENGTH-1:0] doutb,
  output logic [BIT_LENGTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
`ifdef MEM_STREAM_READER_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  dout_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cur_addr_q, next_addr;
  logic [AW:0]           rd_left_q;
  logic                  inflight_q, inflight_last_q;
  logic                  done_zero_q;
  logic [BIT_LENGTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic       accept, fifo_empty, pop, push, fifo_pop, issue, last_read;
  logic [2:0] entries_next;

  assign accept     = start && (state_q == IDLE);
  assign fifo_empty = (count_q == 2'd0);
  assign last_read  = (rd_left_q == (AW+1)'(1));
  assign next_addr  = (cur_addr_q == AW'(DEPTH-1)) ? '0 : cur_addr_q + 1'b1;

  // The word arriving from memory this cycle bypasses the FIFO when it is empty.
  assign dout_valid = !fifo_empty || inflight_q;
  assign dout       = !fifo_empty ? fifo_data[rd_ptr_q] : (inflight_q ? doutb : '0);
  assign dout_last  = !fifo_empty ? fifo_last[rd_ptr_q] : (inflight_q && inflight_last_q);

  assign pop      = dout_valid && dout_ready;
  assign push     = inflight_q && !(fifo_empty && pop);
  assign fifo_pop = pop && !fifo_empty;

  // Occupancy after this cycle, counting the word landing now; a new read lands next cycle.
  assign entries_next = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue        = (state_q == READ) && (entries_next < 3'd2);

  assign enb   = issue;
  assign addrb = cur_addr_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_zero_q || ((state_q == DRAIN) && pop && dout_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (len != '0)) state_d = READ;
      READ:    if (issue && last_read) state_d = DRAIN;
      DRAIN:   if (pop && dout_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      rd_left_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_zero_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_read;
      done_zero_q     <= accept && (len == '0);
      if (accept) begin
        cur_addr_q <= base_addr;
        rd_left_q  <= len;
      end else if (issue) begin
        cur_addr_q <= next_addr;
        rd_left_q  <= rd_left_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr_q] <= doutb;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(fifo_pop);
    end
  end

`ifdef MEM_STREAM_READER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (dout_valid && !dout_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  len;
  logic        busy, done, enb, dout_valid, dout_ready, dout_last;
  logic [3:0]  addrb;
  logic [63:0] doutb, dout;
  logic [63:0] mem [16];
`ifdef MEM_STREAM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [63:0] got[$];
  int addrs[$];
  int lastpos, ndone, first_valid, stalls, hold_err, done_cyc, busy_after;
  int any_busy, extra_valid, extra_enb, nhs;

  mem_stream_reader #(.BIT_LENGTH(64), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .addrb(addrb), .enb(enb), .doutb(doutb),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
`ifdef MEM_STREAM_READER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (enb) doutb <= mem[addrb];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    return (mode == 0) ? 1'b1 : (c % 3 == 0);
  endfunction

  // Runs one command; c counts cycles from the start cycle (c=0).
  task automatic run_cmd(input int b, input int l, input int mode, input int inj);
    logic pv;
    logic [63:0] pd;
    got.delete(); addrs.delete();
    lastpos = -1; ndone = 0; first_valid = -1; stalls = 0; hold_err = 0;
    done_cyc = -1; busy_after = -1; any_busy = 0; extra_valid = 0; extra_enb = 0;
    pv = 1'b0; pd = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'(b); len = 5'(l); dout_ready = ready_pat(mode, 0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy) any_busy++;
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(busy);
      if (done_cyc >= 0 && c > done_cyc) begin
        if (dout_valid) extra_valid++;
        if (enb) extra_enb++;
      end
      if (enb) addrs.push_back(int'(addrb));
      if (dout_valid && first_valid < 0) first_valid = c;
      if (pv && dout !== pd) hold_err++;
      if (dout_valid && !dout_ready) stalls++;
      if (dout_valid && dout_ready) begin
        got.push_back(dout);
        if (dout_last) lastpos = got.size() - 1;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      pv = dout_valid && !dout_ready;
      pd = dout;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
      start = (c + 1 == inj);
      if (c + 1 == inj) begin
        base_addr = 4'd8; len = 5'd2;
      end
      dout_ready = ready_pat(mode, c + 1);
    end
    start = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int b, input int l);
    chk({tag, "_count"}, 64'(got.size()), 64'(l));
    chk({tag, "_naddr"}, 64'(addrs.size()), 64'(l));
    for (int k = 0; k < l && k < got.size(); k++)
      chk({tag, "_data"}, got[k], 64'((b + k) % 16));
    for (int k = 0; k < l && k < addrs.size(); k++)
      chk({tag, "_addr"}, 64'(addrs[k]), 64'((b + k) % 16));
    chk({tag, "_lastpos"}, 64'(lastpos), 64'(l - 1));
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy_after), 64'd0);
    chk({tag, "_hold"}, 64'(hold_err), 64'd0);
    chk({tag, "_extra_valid"}, 64'(extra_valid), 64'd0);
    chk({tag, "_extra_enb"}, 64'(extra_enb), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_enb"}, 64'(enb), 64'd0);
    chk({tag, "_addrb"}, 64'(addrb), 64'd0);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_last"}, 64'(dout_last), 64'd0);
    chk({tag, "_dout"}, dout, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'(i);
    doutb = '0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Basic: base 3, len 4, ready high; valid from cycle 2 to 5, done at cycle 5
    run_cmd(3, 4, 0, -1);
    check_seq("t1", 3, 4);
    chk("t1_first_valid", 64'(first_valid), 64'd2);
    chk("t1_done_cyc", 64'(done_cyc), 64'd5);
    chk("t1_stalls", 64'(stalls), 64'd0);

    // Wrap at DEPTH
    run_cmd(14, 4, 0, -1);
    check_seq("t2", 14, 4);
    chk("t2_word2", got.size() > 2 ? got[2] : 64'hDEAD, 64'd0);

    // Backpressure 1,0,0 repeating: 11 stall cycles, done at cycle 18
    run_cmd(0, 6, 1, -1);
    check_seq("t3", 0, 6);
    chk("t3_stalls", 64'(stalls), 64'd11);
    chk("t3_done_cyc", 64'(done_cyc), 64'd18);
`ifdef MEM_STREAM_READER_STALL_CNT_EN
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd11);
`endif

    // len 0: done the next cycle, nothing else
    run_cmd(7, 0, 0, -1);
    chk("t4_ndone", 64'(ndone), 64'd1);
    chk("t4_done_cyc", 64'(done_cyc), 64'd1);
    chk("t4_any_busy", 64'(any_busy), 64'd0);
    chk("t4_naddr", 64'(addrs.size()), 64'd0);
    chk("t4_first_valid", 64'(first_valid), -64'sd1);

    // Start while busy is ignored
    run_cmd(0, 3, 0, 2);
    check_seq("t5", 0, 3);

    // Full-depth wrap from a non-zero base
    run_cmd(5, 16, 0, -1);
    check_seq("t7", 5, 16);

    // Reset mid-command after two words, then a clean command
    nhs = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd0; len = 5'd8; dout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dout_valid && dout_ready) nhs++;
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 3) begin
        rst_n = 1'b0;
        #2;
        check_reset("t6_midreset");
      end
    end
    chk("t6_words_before_reset", 64'(nhs), 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmd(5, 3, 0, -1);
    check_seq("t6_after", 5, 3);
    chk("t6_first_valid", 64'(first_valid), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
